// File: rtl/uart_pkg.sv
// Shared definitions for the 8-bit UART-with-parity link (receiver and transmitter).
package uart_pkg;
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_rx_state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops reset to RESET_LEVEL.
module uart_rx_sync #(
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_LEVEL;
            q    <= RESET_LEVEL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_receiver_parity.sv
// UART receiver: 1 start, 8 data LSB first, 1 parity, 1 stop; mid-bit sampling,
// single-cycle valid strobe with parity and framing flags. FSM state is visible as `state`.
module uart_receiver_parity
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] dout,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(UART_DATA_BITS - 1);

    uart_rx_state_t state, state_next;
    logic                      rxs;
    logic [CW-1:0]             cnt;
    logic [2:0]                idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      perr;
    logic                      tick;

    uart_rx_sync #(.RESET_LEVEL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxs)
    );

    // The start bit is sampled half a bit in; every later sample is a full bit apart.
    assign tick = (state == START) ? (cnt == HALF_LAST) : (cnt == FULL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            perr       <= 1'b0;
            dout       <= 8'h00;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state <= state_next;
            valid <= 1'b0;
            if (state == IDLE || state == BREAK) begin
                cnt <= '0;
                idx <= '0;
            end else begin
                cnt <= tick ? '0 : cnt + CW'(1);
            end
            if (state == DATA && tick) begin
                shift <= {rxs, shift[UART_DATA_BITS-1:1]};
                idx   <= idx + 3'd1;
            end
            if (state == PARITY && tick) begin
                perr <= (^{shift, rxs}) ^ PARITY_ODD;
            end
            if (state == STOP && tick) begin
                dout       <= shift;
                parity_err <= perr;
                frame_err  <= ~rxs;
                valid      <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!rxs) state_next = START;
            START:   if (tick) state_next = rxs ? IDLE : DATA;
            DATA:    if (tick && idx == IDX_LAST) state_next = PARITY;
            PARITY:  if (tick) state_next = STOP;
            STOP:    if (tick) state_next = rxs ? IDLE : BREAK;
            BREAK:   if (rxs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        if (state != IDLE) busy = 1'b1;
    end
endmodule
